fft_reorder_buffer: RTL and testbench
=====================================

Name: fft_reorder_buffer

Overview:
- Parametrised ping-pong frame buffer that sits between the coefficient source and the FFT datapath, and again between FFT and consumer.
- Accepts one complex IEEE-754 word per cycle in natural order and replays each completed frame in natural or bit-reversed order.
- Uses valid/ready on both sides and a per-frame mode latch.
- Generalises the fixed single-stream FFT I/O to any float width and transform depth, and adds backpressure, frame framing and reorder modes.

Parameters:
- FLOAT_PRECISION, 64, width of each real/imag component (32 or 64).
- logn, 8, log2 of frame depth; DEPTH = 2**logn complex words per frame (logn 3..10).

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input word present
- in_ready  out  1  buffer can accept the input word
- in_mode  in  2  [0]=bit-reversed readout, [1]=inverse frame; sampled on the first word of a frame
- in_last  in  1  source marks the final word of a frame; used for checking only
- fi_re  in  FLOAT_PRECISION  real part
- fi_im  in  FLOAT_PRECISION  imaginary part
- out_valid  out  1  output word present
- out_ready  in  1  consumer accepts the output word
- out_last  out  1  final word of the frame being drained
- out_idx  out  logn  natural-order index of the word on fo_*
- fo_re  out  FLOAT_PRECISION  real out
- fo_im  out  FLOAT_PRECISION  imaginary out
- err  out  1  one-cycle pulse on in_last mismatch

Behaviour:
- Storage: two banks of DEPTH x 2*FLOAT_PRECISION. Each bank has state EMPTY, FILLING, FULL or DRAINING, plus a latched 2-bit mode.
- Write side:
  - wr_bank and wr_cnt (logn bits).
  - in_ready = state[wr_bank] is EMPTY or FILLING.
  - A transfer (in_valid & in_ready) stores the word at address wr_cnt.
  - If wr_cnt==0, the transfer also latches in_mode into that bank and sets the bank to FILLING.
  - When wr_cnt==DEPTH-1: wr_cnt wraps to 0, the bank becomes FULL, and wr_bank toggles.
- Read side:
  - rd_bank and rd_cnt (logn bits).
  - When state[rd_bank] is FULL or DRAINING and the output register is free (!out_valid | out_ready), the block reads address A:
    - A = bitrev(rd_cnt) if mode[0] is set, else A = rd_cnt.
  - The read loads fo_re/fo_im, sets out_idx=A, out_valid=1 and out_last=(rd_cnt==DEPTH-1), and sets the bank to DRAINING.
  - After the last read the bank becomes EMPTY, rd_cnt wraps, and rd_bank toggles.
  - If no new word is loaded and out_ready=1, out_valid drops to 0.
- Latency:
  - The first out_valid of a frame appears 1 cycle after the bank becomes FULL.
  - Sustained throughput is 1 word/cycle with out_ready held high.
  - Writing frame k+1 overlaps draining frame k.
- Output hold: while out_valid=1 & out_ready=0, all outputs hold stable.
- Simultaneous events:
  - A write completing bank X and a read completing bank Y in the same cycle both take effect.
  - The bank a read empties is writable on the next cycle, not the same cycle.
- Full: when both banks are FULL or DRAINING, in_ready=0 and no write occurs regardless of in_valid.
- err:
  - Pulses for 1 cycle when an accepted word has in_last != (wr_cnt==DEPTH-1).
  - The frame count is unaffected; the frame is never truncated.
- Reset (including mid-frame):
  - Both banks EMPTY; all counters and bank pointers 0.
  - out_valid=0, out_last=0, err=0, out_idx=0, fo_re=fo_im=0.
  - in_ready=1 on the first cycle after reset deasserts.
  - Partially written or partially drained frames are discarded.
  - Memory contents are not reset.

Optional Feature:
- Macro: FFT_REORDER_CONJ_EN.
- Defined: for frames with latched mode[1]=1, fo_im is output with its MSB (sign bit) inverted, giving the complex conjugate for inverse-FFT pre/post-processing. The conjugation adds no latency.
- Undefined: mode[1] is stored but ignored; data passes bit-exact.

Decomposition:
- Shared package fft_pkg holds:
  - bank state enum (EMPTY/FILLING/FULL/DRAINING);
  - mode bit positions (MODE_BITREV=0, MODE_INV=1);
  - a bitrev function parametrised on logn.
- One natural sub-module: fft_bank_ram, a single bank with one write port and one asynchronous read port, instantiated twice.

Test Plan (logn=3, DEPTH=8, FLOAT_PRECISION=64):
- Natural mode:
  - Stimulus: write words 0..7 with fi_re = index as double, in_mode=00, out_ready=1.
  - Required: out_idx sequence 0..7 and matching data; out_last only on the 8th word; first out_valid 1 cycle after the 8th write.
- Bit-reversed mode:
  - Stimulus: same frame with in_mode=01.
  - Required: out_idx order 0,4,2,6,1,5,3,7, with fo_re equal to index for each word.
- Backpressure/full:
  - Stimulus: stream 3 frames back-to-back with out_ready=0.
  - Required: after 16 accepted words, in_ready=0; the third frame stalls. Releasing out_ready drains frame 1 then frame 2 intact, and in_ready rises the cycle after frame 1 empties.
- Output stall:
  - Stimulus: toggle out_ready 1,0,0,1 mid-drain.
  - Required: fo_*, out_idx and out_last stay stable while stalled; no word is dropped or duplicated.
- Framing error:
  - Stimulus: assert in_last on word 5.
  - Required: err=1 for exactly one cycle; the frame still completes after 8 words.
- Reset mid-frame:
  - Stimulus: assert rst after 3 writes and during a drain.
  - Required: next cycle out_valid=0, err=0, in_ready=1; the following frame outputs cleanly. With FFT_REORDER_CONJ_EN defined and in_mode=10, fo_im = 64'h3FF0000000000000 input is output as 64'hBFF0000000000000.

Source files
------------

// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
//  Package : fft_pkg
//  Shared bank-state encoding, mode bit positions and index bit reversal
//  used by the FFT reorder buffer.
//  Revision: 1.0
// ============================================================================
package fft_pkg;

   typedef enum logic [1:0] {
      BANK_EMPTY    = 2'd0,
      BANK_FILLING  = 2'd1,
      BANK_FULL     = 2'd2,
      BANK_DRAINING = 2'd3
   } bank_state_t;

   localparam int MODE_BITREV = 0;
   localparam int MODE_INV    = 1;
   localparam int MAX_LOGN    = 10;

   // Reverse the low n bits of v: mirror the full word, then shift the
   // mirrored field back down to bit 0.
   function automatic logic [MAX_LOGN-1:0] bitrev(input logic [MAX_LOGN-1:0] v,
                                                  input int unsigned n);
      logic [MAX_LOGN-1:0] r;
      for (int i = 0; i < MAX_LOGN; i++) begin
         r[i] = v[MAX_LOGN-1-i];
      end
      return r >> (MAX_LOGN - n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/fft_bank_ram.sv
`default_nettype none
// ============================================================================
//  Module  : fft_bank_ram
//  One frame bank: single write port, asynchronous read port, no reset.
//  Revision: 1.0
// ============================================================================
module fft_bank_ram #(
   parameter int WIDTH  = 128,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);

   logic [WIDTH-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/fft_reorder_buffer.sv
`default_nettype none
// ============================================================================
//  Module  : fft_reorder_buffer
//  Ping-pong complex frame buffer: natural-order fill, natural or bit-reversed
//  drain. Optional macro FFT_REORDER_CONJ_EN conjugates inverse-mode frames.
//  Revision: 1.0
// ============================================================================
module fft_reorder_buffer
   import fft_pkg::*;
#(
   parameter int FLOAT_PRECISION = 64,
   parameter int logn            = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [1:0]                 in_mode,
   input  logic                       in_last,
   input  logic [FLOAT_PRECISION-1:0] fi_re,
   input  logic [FLOAT_PRECISION-1:0] fi_im,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       out_last,
   output logic [logn-1:0]            out_idx,
   output logic [FLOAT_PRECISION-1:0] fo_re,
   output logic [FLOAT_PRECISION-1:0] fo_im,
   output logic                       err
);

   localparam int              DW        = 2 * FLOAT_PRECISION;
   localparam logic [logn-1:0] LAST_ADDR = {logn{1'b1}};

   bank_state_t state [2];
   logic [1:0]  mode  [2];
   logic [DW-1:0] rd_data [2];

   logic                       wr_bank;
   logic                       rd_bank;
   logic [logn-1:0]            wr_cnt;
   logic [logn-1:0]            rd_cnt;
   logic [logn-1:0]            rd_addr;
   logic                       wr_fire;
   logic                       rd_fire;
   logic                       rd_avail;
   logic                       out_free;
   logic [DW-1:0]              rd_word;
   logic [FLOAT_PRECISION-1:0] im_next;

   assign in_ready = (state[wr_bank] == BANK_EMPTY) || (state[wr_bank] == BANK_FILLING);
   assign wr_fire  = in_valid && in_ready;

   assign rd_avail = (state[rd_bank] == BANK_FULL) || (state[rd_bank] == BANK_DRAINING);
   assign out_free = !out_valid || out_ready;
   assign rd_fire  = rd_avail && out_free;

   assign rd_addr = mode[rd_bank][MODE_BITREV] ? logn'(bitrev(MAX_LOGN'(rd_cnt), logn)) : rd_cnt;
   assign rd_word = rd_data[rd_bank];

`ifdef FFT_REORDER_CONJ_EN
   // Flipping the sign bit of the imaginary part yields the conjugate.
   assign im_next = rd_word[FLOAT_PRECISION-1:0]
                    ^ {mode[rd_bank][MODE_INV], {(FLOAT_PRECISION-1){1'b0}}};
`else
   logic unused_inv;
   assign unused_inv = mode[0][MODE_INV] ^ mode[1][MODE_INV];
   assign im_next    = rd_word[FLOAT_PRECISION-1:0];
`endif

   for (genvar b = 0; b < 2; b++) begin : g_bank
      fft_bank_ram #(
         .WIDTH  (DW),
         .ADDR_W (logn)
      ) u_ram (
         .clk   (clk),
         .we    (wr_fire && (wr_bank == 1'(b))),
         .waddr (wr_cnt),
         .wdata ({fi_re, fi_im}),
         .raddr (rd_addr),
         .rdata (rd_data[b])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state[0]  <= BANK_EMPTY;
         state[1]  <= BANK_EMPTY;
         mode[0]   <= 2'b00;
         mode[1]   <= 2'b00;
         wr_bank   <= 1'b0;
         rd_bank   <= 1'b0;
         wr_cnt    <= '0;
         rd_cnt    <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_idx   <= '0;
         fo_re     <= '0;
         fo_im     <= '0;
         err       <= 1'b0;
      end else begin
         err <= wr_fire && (in_last != (wr_cnt == LAST_ADDR));

         if (wr_fire) begin
            if (wr_cnt == '0) begin
               mode[wr_bank]  <= in_mode;
               state[wr_bank] <= BANK_FILLING;
            end
            if (wr_cnt == LAST_ADDR) begin
               state[wr_bank] <= BANK_FULL;
               wr_bank        <= ~wr_bank;
            end
            wr_cnt <= wr_cnt + 1'b1;
         end

         // Write and read banks never coincide here: one side requires
         // EMPTY/FILLING, the other FULL/DRAINING.
         if (rd_fire) begin
            fo_re     <= rd_word[DW-1:FLOAT_PRECISION];
            fo_im     <= im_next;
            out_idx   <= rd_addr;
            out_valid <= 1'b1;
            out_last  <= (rd_cnt == LAST_ADDR);
            rd_cnt    <= rd_cnt + 1'b1;
            if (rd_cnt == LAST_ADDR) begin
               state[rd_bank] <= BANK_EMPTY;
               rd_bank        <= ~rd_bank;
            end else begin
               state[rd_bank] <= BANK_DRAINING;
            end
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fft_reorder_buffer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module  : tb_fft_reorder_buffer
//  Randomised self-checking bench with a frame-level reference model.
//  Revision: 1.0
// ============================================================================
module tb_fft_reorder_buffer;

   localparam int FP    = 64;
   localparam int LOGN  = 3;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [1:0]    in_mode = 2'b00;
   logic          in_last = 1'b0;
   logic [FP-1:0] fi_re = '0;
   logic [FP-1:0] fi_im = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic          out_last;
   logic [LOGN-1:0] out_idx;
   logic [FP-1:0] fo_re;
   logic [FP-1:0] fo_im;
   logic          err;

   fft_reorder_buffer #(
      .FLOAT_PRECISION (FP),
      .logn            (LOGN)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_mode   (in_mode),
      .in_last   (in_last),
      .fi_re     (fi_re),
      .fi_im     (fi_im),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .out_idx   (out_idx),
      .fo_re     (fo_re),
      .fo_im     (fo_im),
      .err       (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          idx;
      logic [63:0] re;
      logic [63:0] im;
      bit          last;
      bit          first;
      int          done_cyc;
   } exp_t;

   exp_t        sb[$];
   logic [63:0] m_re [DEPTH];
   logic [63:0] m_im [DEPTH];
   logic [1:0]  m_mode;
   int          m_wpos, m_complete, m_emptied;
   int          cyc, checks, errors, err_seen, policy;
   bit          lat_en;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int rev3(input int k);
      return ((k % 2) * 4) + (((k / 2) % 2) * 2) + ((k / 4) % 2);
   endfunction

   // One clock: apply consumer policy, update the model, then check outputs.
   task automatic tick();
      bit          xfer, exp_err, stall, h_last;
      logic [63:0] h_re, h_im;
      logic [LOGN-1:0] h_idx;
      exp_t        e;
      case (policy)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'b0;
         2:       out_ready = 1'($urandom_range(0, 1));
         default: out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      endcase
      xfer    = in_valid && in_ready;
      exp_err = xfer && (in_last != (m_wpos == DEPTH-1));
      stall   = out_valid && !out_ready;
      h_re = fo_re; h_im = fo_im; h_idx = out_idx; h_last = out_last;
      if (xfer) begin
         if (m_wpos == 0) m_mode = in_mode;
         m_re[m_wpos] = fi_re;
         m_im[m_wpos] = fi_im;
         if (m_wpos == DEPTH-1) begin
            for (int k = 0; k < DEPTH; k++) begin
               int a;
               a = m_mode[0] ? rev3(k) : k;
               e.idx = a;
               e.re  = m_re[a];
               e.im  = m_im[a];
`ifdef FFT_REORDER_CONJ_EN
               if (m_mode[1]) e.im[63] = ~e.im[63];
`endif
               e.last     = (k == DEPTH-1);
               e.first    = (k == 0);
               e.done_cyc = cyc + 1;
               sb.push_back(e);
            end
            m_complete++;
            m_wpos = 0;
         end else begin
            m_wpos++;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      check("err", err, exp_err);
      if (err) err_seen++;
      if (stall) begin
         check("hold_valid", out_valid, 1);
         check("hold_idx", out_idx, h_idx);
         check("hold_re", fo_re, h_re);
         check("hold_im", fo_im, h_im);
         check("hold_last", out_last, h_last);
      end else if (out_valid) begin
         if (sb.size() == 0) begin
            check("spurious_out_valid", out_valid, 0);
         end else begin
            e = sb.pop_front();
            check("out_idx", out_idx, e.idx);
            check("fo_re", fo_re, e.re);
            check("fo_im", fo_im, e.im);
            check("out_last", out_last, e.last);
            if (e.first && lat_en) check("first_latency", cyc - e.done_cyc, 1);
            if (e.last) m_emptied++;
         end
      end
      check("in_ready", in_ready, (m_complete - m_emptied) < 2);
   endtask

   // kind: 0 = re holds the in-frame index as a double, 1 = random, 2 = im = +1.0
   task automatic send_words(input int k0, input int n, input logic [1:0] mode,
                             input int bad_pos, input bit gaps, input int kind,
                             input int budget, output int sent);
      int k, t;
      k = k0; sent = 0; t = 0;
      while (sent < n && t < budget) begin
         in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         in_mode  = mode;
         in_last  = ((k % DEPTH) == DEPTH-1) || ((k % DEPTH) == bad_pos);
         case (kind)
            0:       begin fi_re = $realtobits(real'(k % DEPTH)); fi_im = $realtobits(real'(k)); end
            1:       begin fi_re = {$urandom, $urandom}; fi_im = {$urandom, $urandom}; end
            default: begin fi_re = $realtobits(real'(k % DEPTH)); fi_im = 64'h3FF0000000000000; end
         endcase
         if (in_valid && in_ready) begin
            k++;
            sent++;
         end
         tick();
         t++;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic drain(input int budget);
      int t;
      t = 0;
      in_valid = 1'b0;
      while ((sb.size() != 0 || out_valid) && t < budget) begin
         tick();
         t++;
      end
      check("drain_complete", sb.size(), 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
      rst = 1'b0;
      sb.delete();
      m_wpos = 0; m_complete = 0; m_emptied = 0;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_last", out_last, 0);
      check("rst_err", err, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_idx", out_idx, 0);
      check("rst_fo_re", fo_re, 0);
      check("rst_fo_im", fo_im, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int sent;
      checks = 0; errors = 0; cyc = 0; err_seen = 0; policy = 0; lat_en = 1'b0;
      m_wpos = 0; m_complete = 0; m_emptied = 0;
      repeat (2) @(posedge clk);
      do_reset();

      // natural and bit-reversed single frames into an idle buffer
      lat_en = 1'b1;
      send_words(0, 8, 2'b00, -1, 1'b0, 0, 40, sent);
      check("sent_natural", sent, 8);
      drain(40);
      send_words(0, 8, 2'b01, -1, 1'b0, 0, 40, sent);
      check("sent_bitrev", sent, 8);
      drain(40);
      lat_en = 1'b0;

      // both banks fill while the consumer is stalled
      policy = 1;
      send_words(0, 24, 2'b00, -1, 1'b0, 0, 40, sent);
      check("accepted_while_full", sent, 16);
      check("full_in_ready", in_ready, 0);
      policy = 0;
      send_words(16, 8, 2'b01, -1, 1'b0, 0, 60, sent);
      check("sent_third_frame", sent, 8);
      drain(60);

      // output stall pattern 1,0,0,1
      policy = 3;
      send_words(0, 16, 2'($urandom_range(0, 3)), -1, 1'b0, 1, 200, sent);
      check("sent_stall", sent, 16);
      drain(200);

      // misplaced in_last
      policy = 0;
      err_seen = 0;
      send_words(0, 8, 2'b00, 5, 1'b0, 0, 40, sent);
      check("sent_framing", sent, 8);
      drain(40);
      check("err_pulses", err_seen, 1);

      // randomised traffic
      policy = 2;
      for (int f = 0; f < 6; f++) begin
         send_words(0, 8, 2'($urandom_range(0, 3)), -1, 1'b1, 1, 200, sent);
         check("sent_random", sent, 8);
      end
      drain(400);

      // reset mid-frame, then mid-drain
      policy = 0;
      send_words(0, 3, 2'b00, -1, 1'b0, 1, 20, sent);
      do_reset();
      policy = 1;
      send_words(0, 8, 2'b01, -1, 1'b0, 1, 20, sent);
      policy = 0;
      repeat (3) tick();
      do_reset();
      send_words(0, 8, 2'b10, -1, 1'b0, 2, 40, sent);
      check("sent_after_reset", sent, 8);
      drain(40);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
